crc32_rx_fcs_check: RTL and testbench

- Receive-side Ethernet FCS checker.
- Sits between the MAC RX byte de-framer and the RX packet buffer.
- Computes CRC-32 (polynomial 0x04C11DB7) byte-serially over every received byte, including the trailing 4-byte FCS, and checks the residue.
- Strips the FCS through a 4-byte delay line and flags each frame good or bad on its last payload byte.

---
 rtl/crc32_pkg.sv | 40 ++++
 rtl/crc32_rx_fcs_check_if.sv | 24 ++
 rtl/crc32_d8.sv | 27 ++
 rtl/crc32_rx_fcs_check.sv | 141 ++++++++++++++
 tb/tb_crc32_rx_fcs_check.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FSM state type and the byte-wide update function
// for the receive FCS checker.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Ethernet sends each byte LSB first; reversing it lets the MSB-first
  // register see the bits in wire order.
  function automatic logic [7:0] bitrev8(input logic [7:0] data);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r = {r[6:0], data[0]};
      data = data >> 1;
    end
    return r;
  endfunction

  // MSB-first Galois update of the CRC register by one (already reversed) byte.
  function automatic logic [31:0] crc32_upd8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc;
    b = data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[31] ^ b[7]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else              c = {c[30:0], 1'b0};
      b = {b[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_rx_fcs_check_if.sv
// Byte stream into and out of the FCS checker.
// master: the de-framer/buffer side; slave: the checker.
interface crc32_rx_fcs_check_if;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;
  logic       out_abort;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_sop, in_eop, in_data,
    input  out_valid, out_sop, out_eop, out_err, out_abort, out_data
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data,
    output out_valid, out_sop, out_eop, out_err, out_abort, out_data
  );
endinterface

// File: rtl/crc32_d8.sv
// Registered byte-serial CRC-32 engine. crc_next is the register value after
// the current byte; sop restarts the computation from the init value.
module crc32_d8
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sop,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] crc;

  // Next CRC value for the byte on the input, seeded fresh on sop.
  always_comb begin
    crc_next = crc32_upd8(sop ? CRC32_INIT : crc, bitrev8(data));
  end

  // CRC register advances on every accepted byte.
  always_ff @(posedge clk) begin
    if (!rst)    crc <= CRC32_INIT;
    else if (en) crc <= crc_next;
  end

endmodule

// File: rtl/crc32_rx_fcs_check.sv
// Receive-side Ethernet FCS checker: CRC-32 residue check over every byte,
// FCS stripped by a 4-byte delay line, good/bad flag on the last payload byte.
// Optional statistics counters enabled by defining CRC_RX_STATS_EN.
module crc32_rx_fcs_check
  import crc32_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  crc32_rx_fcs_check_if.slave   bus,
  output logic [CNT_W-1:0]      stat_good,
  output logic [CNT_W-1:0]      stat_bad,
  output logic [CNT_W-1:0]      stat_runt
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);

  state_t            state;
  logic [15:0]       cnt;
  logic [2:0]        occ;
  logic [3:0][7:0]   dly;
  logic              emitted;

  logic              acc;
  logic              abort_ev;
  logic              emit;
  logic [15:0]       cnt_n;
  logic              short_frm;
  logic              crc_ok;
  logic [31:0]       crc_next;

  crc32_d8 u_crc (
    .clk      (clk),
    .rst      (rst),
    .en       (acc),
    .sop      (bus.in_sop),
    .data     (bus.in_data),
    .crc_next (crc_next)
  );

  // Byte acceptance, length tracking and frame classification for this byte.
  always_comb begin
    acc       = bus.in_valid && (state == RUN || bus.in_sop);
    abort_ev  = acc && bus.in_sop && state == RUN;
    emit      = acc && !bus.in_sop && occ == 3'd4;
    if (bus.in_sop)      cnt_n = 16'd1;
    else if (cnt == '1)  cnt_n = cnt;
    else                 cnt_n = cnt + 16'd1;
    // Frames of 4 bytes or less carry no payload and are always runts.
    short_frm = cnt_n < MIN_LEN16 || cnt_n <= 16'd4;
    crc_ok    = crc_next == RESIDUE;
  end

  // FSM, delay line and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      occ           <= '0;
      dly           <= '0;
      emitted       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_abort <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_abort <= 1'b0;
      bus.out_data  <= '0;
      if (acc) begin
        cnt <= cnt_n;
        dly <= {dly[2:0], bus.in_data};
        // A sop restarts the line at one entry; the previous frame's
        // leftovers are dropped and an abort flagged if any were emitted.
        if (bus.in_sop) begin
          bus.out_abort <= abort_ev && emitted;
          occ           <= 3'd1;
          emitted       <= 1'b0;
        end else if (occ != 3'd4) begin
          occ <= occ + 3'd1;
        end
        if (emit) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= dly[3];
          bus.out_sop   <= !emitted;
          bus.out_eop   <= bus.in_eop;
          bus.out_err   <= bus.in_eop && (short_frm || !crc_ok);
          emitted       <= 1'b1;
        end
        if (bus.in_eop) begin
          state   <= IDLE;
          occ     <= '0;
          emitted <= 1'b0;
        end else begin
          state <= RUN;
        end
      end
    end
  end

`ifdef CRC_RX_STATS_EN
  logic eop_ev;
  logic good_ev;
  logic bad_ev;
  logic runt_ev;

  // Frame outcome events; runt takes precedence over a CRC error.
  always_comb begin
    eop_ev  = acc && bus.in_eop;
    runt_ev = eop_ev && short_frm;
    good_ev = eop_ev && !short_frm && crc_ok;
    bad_ev  = abort_ev || (eop_ev && !short_frm && !crc_ok);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_good <= '0;
      stat_bad  <= '0;
      stat_runt <= '0;
    end else begin
      if (good_ev && stat_good != '1) stat_good <= stat_good + CNT_W'(1);
      if (bad_ev  && stat_bad  != '1) stat_bad  <= stat_bad  + CNT_W'(1);
      if (runt_ev && stat_runt != '1) stat_runt <= stat_runt + CNT_W'(1);
    end
  end
`else
  assign stat_good = '0;
  assign stat_bad  = '0;
  assign stat_runt = '0;
`endif

endmodule

// File: tb/tb_crc32_rx_fcs_check.sv
// Directed bench for crc32_rx_fcs_check: two instances (MIN_LEN 5 and 64)
// fed the same byte stream; output records compared against expected queues.
module tb_crc32_rx_fcs_check;

`ifdef CRC_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [11:0] rec_t; // {abort, sop, eop, err, data}

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v = 1'b0, s = 1'b0, e = 1'b0;
  logic [7:0] d = '0;
  logic vin_prev = 1'b0;
  int stray = 0;

  logic [15:0] sga, sba, sra, sgb, sbb, srb;

  crc32_rx_fcs_check_if bus_a ();
  crc32_rx_fcs_check_if bus_b ();

  assign bus_a.in_valid = v;
  assign bus_a.in_sop   = s;
  assign bus_a.in_eop   = e;
  assign bus_a.in_data  = d;
  assign bus_b.in_valid = v;
  assign bus_b.in_sop   = s;
  assign bus_b.in_eop   = e;
  assign bus_b.in_data  = d;

  crc32_rx_fcs_check #(.MIN_LEN(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .stat_good(sga), .stat_bad(sba), .stat_runt(sra)
  );

  crc32_rx_fcs_check #(.MIN_LEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .stat_good(sgb), .stat_bad(sbb), .stat_runt(srb)
  );

  always #5 clk = ~clk;

  rec_t qa[$], qb[$], ea[$], eb[$];
  int n_cmp = 0, n_err = 0;
  int xga = 0, xba = 0, xra = 0, xgb = 0, xbb = 0, xrb = 0;

  always @(posedge clk) vin_prev <= v;

  // Collect everything either instance emits, sampled away from the edge.
  always @(negedge clk) begin
    if (bus_a.out_valid || bus_a.out_abort)
      qa.push_back({bus_a.out_abort, bus_a.out_sop, bus_a.out_eop, bus_a.out_err, bus_a.out_data});
    if (bus_b.out_valid || bus_b.out_abort)
      qb.push_back({bus_b.out_abort, bus_b.out_sop, bus_b.out_eop, bus_b.out_err, bus_b.out_data});
    if (bus_a.out_valid && !vin_prev) stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] db, input logic sb, input logic eb_);
    @(negedge clk);
    v = 1'b1; s = sb; e = eb_; d = db;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      v = 1'b0; s = 1'b0; e = 1'b0; d = '0;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps, input bit no_eop);
    for (int i = 0; i < f.size(); i++) begin
      send(f[i], i == 0, (i == f.size() - 1) && !no_eop);
      if (gaps) gap(i % 3);
    end
  endtask

  task automatic add_exp(input bit to_b, input logic [7:0] p[$], input int n,
                         input bit eop_last, input bit err);
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r = {1'b0, (i == 0), (eop_last && i == n - 1), (err && eop_last && i == n - 1), p[i]};
      if (to_b) eb.push_back(r);
      else      ea.push_back(r);
    end
  endtask

  task automatic cmp_q(input string tag, input rec_t got[$], input rec_t exp[$]);
    chk({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic cmp_all(input string tag);
    cmp_q({tag, ".a"}, qa, ea);
    cmp_q({tag, ".b"}, qb, eb);
    qa.delete(); qb.delete(); ea.delete(); eb.delete();
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".a.good"}, sga, STATS ? xga : 0);
    chk({tag, ".a.bad"},  sba, STATS ? xba : 0);
    chk({tag, ".a.runt"}, sra, STATS ? xra : 0);
    chk({tag, ".b.good"}, sgb, STATS ? xgb : 0);
    chk({tag, ".b.bad"},  sbb, STATS ? xbb : 0);
    chk({tag, ".b.runt"}, srb, STATS ? xrb : 0);
  endtask

  // Reference FCS via the reflected (LSB-first) CRC-32 form with final XOR.
  function automatic logic [31:0] ref_fcs(input logic [7:0] f[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  initial begin
    logic [7:0] kv[$];
    logic [7:0] kv_bad[$];
    logic [7:0] p56[$];
    logic [7:0] f60[$];
    logic [7:0] p20[$];
    logic [7:0] f3[$];
    logic [31:0] fcs;

    kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    kv_bad = kv;
    kv_bad[12] = 8'hCA;
    for (int i = 0; i < 56; i++) p56.push_back(8'(i * 37 + 5));
    fcs = ref_fcs(p56);
    f60 = p56;
    f60.push_back(fcs[7:0]);
    f60.push_back(fcs[15:8]);
    f60.push_back(fcs[23:16]);
    f60.push_back(fcs[31:24]);
    for (int i = 0; i < 20; i++) p20.push_back(p56[i]);
    f3 = '{8'hA1, 8'hA2, 8'hA3};

    // Reset state
    gap(3);
    chk("reset.a.out", {bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_err,
                        bus_a.out_abort, bus_a.out_data}, 0);
    chk_stats("reset");
    rst = 1'b1;
    gap(2);

    // Known vector: good at MIN_LEN 5, runt at MIN_LEN 64
    send_frame(kv, 1'b0, 1'b0);
    gap(4);
    add_exp(1'b0, kv, 9, 1'b1, 1'b0);
    add_exp(1'b1, kv, 9, 1'b1, 1'b1);
    xga++; xrb++;
    cmp_all("known");
    chk_stats("known");

    // Corrupted FCS: CRC error at MIN_LEN 5, runt only at MIN_LEN 64
    send_frame(kv_bad, 1'b0, 1'b0);
    gap(4);
    add_exp(1'b0, kv, 9, 1'b1, 1'b1);
    add_exp(1'b1, kv, 9, 1'b1, 1'b1);
    xba++; xrb++;
    cmp_all("badfcs");
    chk_stats("badfcs");

    // Known vector with idle gaps between bytes
    stray = 0;
    send_frame(kv, 1'b1, 1'b0);
    gap(4);
    add_exp(1'b0, kv, 9, 1'b1, 1'b0);
    add_exp(1'b1, kv, 9, 1'b1, 1'b1);
    xga++; xrb++;
    cmp_all("gaps");
    chk("gaps.stray", stray, 0);
    chk_stats("gaps");

    // 60-byte frame with valid FCS: good at 5, runt at 64
    send_frame(f60, 1'b0, 1'b0);
    gap(4);
    add_exp(1'b0, p56, 56, 1'b1, 1'b0);
    add_exp(1'b1, p56, 56, 1'b1, 1'b1);
    xga++; xrb++;
    cmp_all("len60");
    chk_stats("len60");

    // Missing eop: 20 bytes then a new frame on sop
    send_frame(p20, 1'b0, 1'b1);
    send_frame(kv, 1'b0, 1'b0);
    gap(4);
    add_exp(1'b0, p20, 16, 1'b0, 1'b0);
    add_exp(1'b1, p20, 16, 1'b0, 1'b0);
    ea.push_back(12'h800);
    eb.push_back(12'h800);
    add_exp(1'b0, kv, 9, 1'b1, 1'b0);
    add_exp(1'b1, kv, 9, 1'b1, 1'b1);
    xba++; xga++; xbb++; xrb++;
    cmp_all("abort");
    chk_stats("abort");

    // 3-byte frame: nothing emitted, runt
    send_frame(f3, 1'b0, 1'b0);
    gap(4);
    xra++; xrb++;
    cmp_all("len3");
    chk_stats("len3");

    // Single byte with sop and eop together
    send(8'h5A, 1'b1, 1'b1);
    gap(4);
    xra++; xrb++;
    cmp_all("len1");
    chk_stats("len1");

    // Bytes without sop while idle are ignored
    for (int i = 0; i < 6; i++) send(8'(8'h70 + i), 1'b0, i == 5);
    gap(4);
    cmp_all("nosop");
    chk_stats("nosop");

    // Reset in the middle of a frame that is already emitting
    for (int i = 0; i < 8; i++) send(kv[i], i == 0, 1'b0);
    @(negedge clk);
    rst = 1'b0; v = 1'b1; s = 1'b0; e = 1'b0; d = kv[8];
    @(negedge clk);
    xga = 0; xba = 0; xra = 0; xgb = 0; xbb = 0; xrb = 0;
    chk("midrst.a.out", {bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_err,
                         bus_a.out_abort, bus_a.out_data}, 0);
    chk("midrst.b.out", {bus_b.out_valid, bus_b.out_sop, bus_b.out_eop, bus_b.out_err,
                         bus_b.out_abort, bus_b.out_data}, 0);
    chk_stats("midrst");
    qa.delete(); qb.delete();
    rst = 1'b1;
    for (int i = 9; i < 13; i++) send(kv[i], 1'b0, i == 12);
    gap(4);
    cmp_all("midrst.tail");
    chk_stats("midrst.tail");

    // Normal operation after the reset
    send_frame(kv, 1'b0, 1'b0);
    gap(4);
    add_exp(1'b0, kv, 9, 1'b1, 1'b0);
    add_exp(1'b1, kv, 9, 1'b1, 1'b1);
    xga++; xrb++;
    cmp_all("post");
    chk_stats("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
